// File: rtl/counter_sequencer_if.sv
// Front-panel bundle for the stopwatch sequencer.
//   KEY[3:0]  pushbuttons, active-low (KEY[0] doubles as the reset)
//   SW[9:0]   target value / direction switches
//   LEDR[9:0] displayed count, running and done indicators
// master: the board / testbench side that drives keys and switches.
// slave : the sequencer, which reads keys and switches and drives LEDR.
interface counter_sequencer_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  modport master (output KEY, output SW, input LEDR);
  modport slave  (input KEY, input SW, output LEDR);
endinterface

// File: rtl/counter_sequencer.sv
// Run-control sequencer for an 8-bit stopwatch/timer event counter.
// Pushbutton presses are synchronized and edge-detected into one-cycle
// pulses that start/pause, lap-freeze and clear the counter; a prescaler
// produces the counting tick. The count counts up toward a target
// (0 = free-running) or down to zero, as selected at start.
//
// Ports:
//   CLOCK_50  system clock, all state changes on its rising edge
//   bus.KEY   [0] synchronous active-low reset, [1] start/stop,
//             [2] lap, [3] clear (buttons active-low)
//   bus.SW    [7:0] target, [9] direction (1 = down), [8] unused
//   bus.LEDR  [7:0] live or lap-frozen count, [8] running, [9] done
//
// state | meaning
// IDLE  | count follows the switches, waiting for start
// RUN   | prescaler advancing, count updated on each tick
// PAUSE | count and prescaler frozen, start resumes
// DONE  | terminal value reached, only clear or reset leave
module counter_sequencer #(
  parameter int PRESCALE = 50000000,
  parameter int PW       = 26
) (
  input logic            CLOCK_50,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t state_q, state_d;

  logic          resetn;
  logic [2:0]    key_s1, key_s2, key_prev;
  logic          start_p, lap_p, clear_p;
  logic [7:0]    count_q, count_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    lap_reg_q, lap_reg_d;
  logic          dir_q, dir_d;
  logic          lap_hold_q, lap_hold_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ledr_q;
  logic          tick;
  logic [7:0]    count_step;
  logic          reached;
  logic          unused_sw8;

  assign resetn     = bus.KEY[0];
  assign unused_sw8 = bus.SW[8];
  assign bus.LEDR   = ledr_q;

  // Falling edge of the synchronized (active-low) button level.
  assign {clear_p, lap_p, start_p} = key_prev & ~key_s2;

  assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign count_step = dir_q ? (count_q - 8'd1) : (count_q + 8'd1);
  // Up-count with a zero target never terminates.
  assign reached    = dir_q ? (count_step == 8'd0)
                            : ((target_q != 8'd0) && (count_step == target_q));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      target_q   <= '0;
      dir_q      <= 1'b0;
      presc_q    <= '0;
      lap_hold_q <= 1'b0;
      lap_reg_q  <= '0;
      key_s1     <= 3'b111;
      key_s2     <= 3'b111;
      key_prev   <= 3'b111;
      ledr_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      presc_q    <= presc_d;
      lap_hold_q <= lap_hold_d;
      lap_reg_q  <= lap_reg_d;
      key_s1     <= bus.KEY[3:1];
      key_s2     <= key_s1;
      key_prev   <= key_s2;
      ledr_q     <= {state_q == DONE, state_q == RUN,
                     lap_hold_q ? lap_reg_q : count_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    dir_d      = dir_q;
    presc_d    = presc_q;
    lap_hold_d = lap_hold_q;
    lap_reg_d  = lap_reg_q;

    if (clear_p) begin
      state_d    = IDLE;
      presc_d    = '0;
      lap_hold_d = 1'b0;
    end else begin
      // Lap toggles the freeze; the capture sees the pre-tick count.
      if ((state_q == RUN || state_q == PAUSE) && lap_p) begin
        if (lap_hold_q) begin
          lap_hold_d = 1'b0;
        end else begin
          lap_hold_d = 1'b1;
          lap_reg_d  = count_q;
        end
      end

      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          count_d = bus.SW[9] ? bus.SW[7:0] : 8'd0;
          if (start_p) begin
            target_d = bus.SW[7:0];
            dir_d    = bus.SW[9];
            if (bus.SW[9] && (bus.SW[7:0] == 8'd0)) begin
              state_d    = DONE;
              lap_hold_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (start_p) state_d = PAUSE;
          // A terminal tick wins over a same-cycle pause request.
          if (tick) begin
            count_d = count_step;
            if (reached) begin
              state_d    = DONE;
              lap_hold_d = 1'b0;
            end
          end
        end
        PAUSE: begin
          if (start_p) state_d = RUN;
        end
        DONE: begin
          presc_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int PRESCALE = 4;

  localparam int A_NONE  = 0;
  localparam int A_START = 1;
  localparam int A_LAP   = 2;
  localparam int A_CLEAR = 3;
  localparam int A_RST   = 4;
  localparam int A_CLST  = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int         act;
    logic [9:0] sw;
    int         wt;
    logic [9:0] exp;
  } vec_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  counter_sequencer_if bus();

  counter_sequencer #(.PRESCALE(PRESCALE), .PW(3)) dut (
    .CLOCK_50 (clk),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: button history, mode and count kept as plain integers.
  int         m_mode   = M_IDLE;
  int         m_count  = 0;
  int         m_target = 0;
  int         m_dir    = 0;
  int         m_phase  = 0;
  int         m_hold   = 0;
  int         m_lap    = 0;
  logic [9:0] m_ledr   = '0;
  logic [2:0] hist [3] = '{3'b111, 3'b111, 3'b111};

  always @(posedge clk) begin
    logic [2:0] pulse;
    bit         tk;
    bit         term;
    if (!bus.KEY[0]) begin
      m_mode = M_IDLE; m_count = 0; m_target = 0; m_dir = 0;
      m_phase = 0; m_hold = 0; m_lap = 0; m_ledr = '0;
      hist[0] = 3'b111; hist[1] = 3'b111; hist[2] = 3'b111;
    end else begin
      m_ledr = {m_mode == M_DONE, m_mode == M_RUN,
                8'(m_hold != 0 ? m_lap : m_count)};
      // Key value seen three edges ago released, two edges ago pressed.
      pulse = hist[2] & ~hist[1];
      if (pulse[2]) begin
        m_mode = M_IDLE; m_phase = 0; m_hold = 0;
      end else if (m_mode == M_IDLE) begin
        m_count = bus.SW[9] ? int'(bus.SW[7:0]) : 0;
        if (pulse[0]) begin
          m_target = int'(bus.SW[7:0]);
          m_dir    = int'(bus.SW[9]);
          m_mode   = (m_dir == 1 && m_target == 0) ? M_DONE : M_RUN;
        end
      end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
        if (pulse[1]) begin
          if (m_hold != 0) m_hold = 0;
          else begin m_hold = 1; m_lap = m_count; end
        end
        if (m_mode == M_RUN) begin
          tk = (m_phase == PRESCALE - 1);
          m_phase = tk ? 0 : m_phase + 1;
          if (pulse[0]) m_mode = M_PAUSE;
          if (tk) begin
            m_count = (m_count + (m_dir != 0 ? 255 : 1)) % 256;
            term = (m_dir != 0) ? (m_count == 0)
                                : (m_target != 0 && m_count == m_target);
            if (term) begin m_mode = M_DONE; m_hold = 0; end
          end
        end else if (pulse[0]) begin
          m_mode = M_RUN;
        end
      end else begin
        m_phase = 0;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.KEY[3:1];
    end
  end

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got LEDR=%h want %h", name, got, exp);
    end
  endtask

  task automatic press(input logic [2:0] mask);
    bus.KEY[3:1] = ~mask;
    @(negedge clk);
    bus.KEY[3:1] = 3'b111;
  endtask

  task automatic do_act(input int a);
    case (a)
      A_START: press(3'b001);
      A_LAP:   press(3'b010);
      A_CLEAR: press(3'b100);
      A_CLST:  press(3'b101);
      A_RST: begin
        bus.KEY[0] = 1'b0;
        @(negedge clk);
        bus.KEY[0] = 1'b1;
      end
      default: ;
    endcase
  endtask

  function automatic vec_t mk(input int a, input logic [9:0] s, input int w, input logic [9:0] e);
    vec_t v;
    v.act = a; v.sw = s; v.wt = w; v.exp = e;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    bus.KEY = 4'hF;
    bus.SW  = '0;

    // Free-running up count and 255 -> 0 wrap
    vq.push_back(mk(A_RST,   10'h000,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h000,    4, 10'h101));
    vq.push_back(mk(A_NONE,  10'h000,    8, 10'h103));
    vq.push_back(mk(A_NONE,  10'h000, 1008, 10'h1FF));
    vq.push_back(mk(A_NONE,  10'h000,    4, 10'h100));
    // Up to target 5, then starts ignored in DONE
    vq.push_back(mk(A_RST,   10'h005,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h005,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h005,   19, 10'h104));
    vq.push_back(mk(A_NONE,  10'h005,    1, 10'h205));
    vq.push_back(mk(A_START, 10'h005,   10, 10'h205));
    // Down from 3
    vq.push_back(mk(A_RST,   10'h203,    3, 10'h003));
    vq.push_back(mk(A_START, 10'h203,    3, 10'h103));
    vq.push_back(mk(A_NONE,  10'h203,   11, 10'h101));
    vq.push_back(mk(A_NONE,  10'h203,    1, 10'h200));
    // Down from 0: immediate DONE
    vq.push_back(mk(A_RST,   10'h200,    3, 10'h000));
    vq.push_back(mk(A_START, 10'h200,    3, 10'h200));
    // Pause mid-period, resume finishes the remaining prescale cycles
    vq.push_back(mk(A_RST,   10'h000,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h000,    6, 10'h101));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h002));
    vq.push_back(mk(A_NONE,  10'h000,   20, 10'h002));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h102));
    vq.push_back(mk(A_NONE,  10'h000,    1, 10'h102));
    vq.push_back(mk(A_NONE,  10'h000,    1, 10'h103));
    // Lap freeze at 3, release shows live count
    vq.push_back(mk(A_RST,   10'h000,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h000,    9, 10'h102));
    vq.push_back(mk(A_LAP,   10'h000,    3, 10'h103));
    vq.push_back(mk(A_NONE,  10'h000,   12, 10'h103));
    vq.push_back(mk(A_LAP,   10'h000,    3, 10'h107));
    // Clear + start together in RUN; switch change in RUN has no effect
    vq.push_back(mk(A_RST,   10'h000,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h000,    9, 10'h102));
    vq.push_back(mk(A_CLST,  10'h207,    4, 10'h007));
    vq.push_back(mk(A_NONE,  10'h207,    4, 10'h007));
    // Reset while running with lap held
    vq.push_back(mk(A_RST,   10'h000,    2, 10'h000));
    vq.push_back(mk(A_START, 10'h000,    3, 10'h100));
    vq.push_back(mk(A_NONE,  10'h000,    9, 10'h102));
    vq.push_back(mk(A_LAP,   10'h000,    3, 10'h103));
    vq.push_back(mk(A_RST,   10'h000,    0, 10'h000));
    vq.push_back(mk(A_NONE,  10'h000,    8, 10'h000));

    @(negedge clk);
    foreach (vq[i]) begin
      bus.SW = vq[i].sw;
      do_act(vq[i].act);
      repeat (vq[i].wt) @(negedge clk);
      check($sformatf("vec%0d", i), bus.LEDR, vq[i].exp);
    end

    // Randomized buttons, switches and occasional reset against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check($sformatf("rand%0d", c), bus.LEDR, m_ledr);
      for (int b = 1; b < 4; b++)
        if ($urandom_range(0, 11) == 0) bus.KEY[b] = ~bus.KEY[b];
      if ($urandom_range(0, 39) == 0)
        bus.SW = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 12))};
      bus.KEY[0] = ($urandom_range(0, 599) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control sequencer for an 8-bit event counter. The block is a stopwatch/timer controller for the DE1-SoC style top level. It takes debounced-free pushbutton presses (start/stop, lap, clear) and a switch-selected target. It drives an internal prescaled tick into the counter, which counts up or down. The run state, the terminal "done" flag and either the live or a lap-frozen count value are shown on LEDR.

Parameters:
PRESCALE, 50000000, CLOCK_50 cycles per counter tick (benches override to a small value, e.g. 4)
PW, 26, prescaler register width; must satisfy 2^PW >= PRESCALE

Ports:
CLOCK_50  input  1  system clock; all state updates on its rising edge
KEY  input  4  KEY[0] = Resetn, synchronous active-low reset; KEY[1] start/stop, KEY[2] lap, KEY[3] clear (pushbuttons are active-low)
SW  input  10  SW[7:0] target value; SW[9] direction (0 = up, 1 = down); SW[8] unused
LEDR  output  10  LEDR[7:0] displayed count; LEDR[8] running; LEDR[9] done

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is synchronous and active-low on KEY[0], sampled on the clock edge.
- Reset state:
  - state=IDLE, count=0, target=0, dir=0, prescaler=0, lap_hold=0, lap_reg=0.
  - Key sync flops set to 1 (released). LEDR=0.
- KEY[3:1] input path:
  - Each button passes through a 2-flop synchronizer, then a falling-edge detector (sync value 1 -> 0).
  - Each press produces a one-cycle pulse: start_p, lap_p, clear_p.
  - The FSM acts on a pulse in the cycle it is asserted.
  - Holding a button produces exactly one pulse.
- Prescaler:
  - Increments only in RUN. When it equals PRESCALE-1, tick=1 and it wraps to 0.
  - Holds its value in PAUSE.
  - Cleared to 0 in IDLE and DONE.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - count is continuously loaded: 0 if SW[9]=0, SW[7:0] if SW[9]=1.
  - On start_p: latch target<=SW[7:0] and dir<=SW[9].
  - Then, if dir=1 and SW[7:0]==0, go to DONE; otherwise go to RUN.
- RUN:
  - On tick with dir=0: count<=count+1, wrapping 255 -> 0.
    - If target != 0 and count+1 == target, go to DONE.
    - target=0 means free-running.
  - On tick with dir=1: count<=count-1. When the new value is 0, go to DONE.
  - start_p goes to PAUSE. If tick is in the same cycle, the tick update is applied first.
- PAUSE: count and prescaler hold. start_p returns to RUN.
- DONE: count holds at its terminal value. start_p and lap_p are ignored.
- clear_p:
  - Valid in any state; goes to IDLE, prescaler=0, lap_hold=0.
  - Has priority over start_p, lap_p and tick arriving in the same cycle.
- Lap:
  - In RUN or PAUSE, lap_p with lap_hold=0 captures lap_reg<=count (the pre-update value if tick is in the same cycle) and sets lap_hold=1.
  - lap_p with lap_hold=1 clears lap_hold.
  - Entering DONE clears lap_hold.
  - Counting continues while lap_hold=1.
- Outputs: LEDR is registered, reflecting internal state with one cycle of latency.
  - LEDR[7:0] = lap_hold ? lap_reg : count.
  - LEDR[8] = (state==RUN).
  - LEDR[9] = (state==DONE).
- Switch timing: SW changes after start_p have no effect until the next IDLE start.
- Reset mid-operation: KEY[0] low for one edge returns everything to reset values regardless of state or pending pulses.
- Latency: button falling edge to FSM reaction = 3 clocks (2 sync + 1 edge register). LEDR follows 1 clock later.

Test Plan (PRESCALE=4):
- Reset, SW=0x000, press KEY[1] -> LEDR[8]=1. LEDR[7:0] increments 0,1,2... every 4 clocks; free-running 255 -> 0 wrap is observed.
- SW[9]=0, SW[7:0]=5, start -> LEDR[7:0] reaches 5 after 20 clocks of RUN. Then LEDR[9]=1, LEDR[8]=0, and the count stays at 5 under further start presses.
- SW[9]=1, SW[7:0]=3, start -> count goes 3,2,1,0, then DONE. Repeat with SW[7:0]=0 -> DONE immediately, LEDR[7:0]=0.
- Start, then after 2 ticks press start -> PAUSE: count=2 and the prescaler is frozen. Press start again -> the next tick arrives after the remaining prescale cycles, not a full 4.
- In RUN at count=3, press lap -> LEDR[7:0] stays 3 while the internal count advances. Press lap again -> LEDR shows the live count (e.g. 6).
- Same-cycle events:
  - clear and start together in RUN -> IDLE, count reload.
  - KEY[0]=0 during RUN with lap_hold=1 -> LEDR=0 next cycle, state IDLE.
